// File: rtl/instruction_fetch_unit.sv
// Fetch-side initiator for the 16-bit instruction memory: holds the PC, captures and issues
// instructions with a valid/ready handshake, resolves jmp/jez, halt and fault. Option: JUMP_COUNT_EN.
module instruction_fetch_unit #(
  parameter int unsigned MEM_DEPTH = 64,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [2:0]  OPC_JMP   = 3'b100,
  parameter logic [2:0]  OPC_JEZ   = 3'b101
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] imem_abus,
  input  logic [15:0] imem_dbus,
  input  logic        zero_flag,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        halted,
  output logic        fault
`ifdef JUMP_COUNT_EN
  ,
  output logic [15:0] jump_count
`endif
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } state_e;

  localparam logic [15:0] PC_LIMIT = 16'(MEM_DEPTH);

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;

  logic [2:0]  opcode_s;
  logic [15:0] target_s;
  logic [15:0] next_pc_s;
  logic        taken_s;
  logic        handshake_s;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= 16'h0000;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // Branch resolution on the held instruction; zero_flag only matters in the handshake cycle
  always_comb begin
    opcode_s    = instr_q[15:13];
    target_s    = {3'b000, instr_q[12:0]};
    handshake_s = valid_q & instr_ready;
    if (opcode_s == OPC_JMP) begin
      taken_s = 1'b1;
    end else if (opcode_s == OPC_JEZ) begin
      taken_s = zero_flag;
    end else begin
      taken_s = 1'b0;
    end
    if (taken_s) begin
      next_pc_s = target_s;
    end else begin
      next_pc_s = instr_pc_q + 16'd1;
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    case (state_q)
      FETCH: begin
        if (pc_q >= PC_LIMIT) begin
          state_d = FAULT;
          fault_d = 1'b1;
          valid_d = 1'b0;
        end else begin
          instr_d    = imem_dbus;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake_s) begin
          valid_d = 1'b0;
          // A taken jump back to its own address is the halt idiom; PC stays put
          if (taken_s && (target_s == instr_pc_q)) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            pc_d    = next_pc_s;
            state_d = FETCH;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
        fault_d  = 1'b0;
      end
      FAULT: begin
        valid_d  = 1'b0;
        fault_d  = 1'b1;
        halted_d = 1'b0;
      end
      default: begin
        state_d  = FETCH;
        pc_d     = RESET_PC;
        valid_d  = 1'b0;
        halted_d = 1'b0;
        fault_d  = 1'b0;
      end
    endcase
  end

  assign imem_abus   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

`ifdef JUMP_COUNT_EN
  logic [15:0] jcnt_q, jcnt_d;

  // Saturating count of accepted taken jumps, halt entry included
  always_comb begin
    jcnt_d = jcnt_q;
    if ((state_q == ISSUE) && handshake_s && taken_s && (jcnt_q != 16'hFFFF)) begin
      jcnt_d = jcnt_q + 16'd1;
    end else begin
      jcnt_d = jcnt_q;
    end
  end

  // Jump counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jcnt_q <= 16'h0000;
    end else begin
      jcnt_q <= jcnt_d;
    end
  end

  assign jump_count = jcnt_q;
`endif

endmodule
